// File: rtl/mlp_weight_loader.sv
// Weight broadcast transmitter: tags each streamed 16-bit weight with layer/index and emits the 32-bit MLP weight word.
// Optional running checksum of accepted weights is built only when MLP_WLOAD_CHKSUM_EN is defined.
module mlp_weight_loader #(
    parameter int W_LEN0 = 15,
    parameter int W_LEN1 = 24,
    parameter int W_LEN2 = 24,
    parameter int W_LEN3 = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [15:0] s_tdata,
    input  logic        s_tlast,
    output logic [31:0] w_tdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] chksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  layer;
    logic [6:0]  index;
    logic [6:0]  layer_len_m1;
    logic        xfer;
    logic        last_in_layer;
    logic        final_word;
    logic        start_pass;

    // Handshake: a weight moves only on a cycle where s_tvalid and s_tready are both high;
    // s_tready depends on state alone, never on s_tvalid.
    assign s_tready = (state == LOAD);
    assign xfer     = s_tvalid & s_tready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign start_pass = (state == IDLE) && start;

    always_comb begin
        layer_len_m1 = 7'(W_LEN0 - 1);
        case (layer)
            2'd0: layer_len_m1 = 7'(W_LEN0 - 1);
            2'd1: layer_len_m1 = 7'(W_LEN1 - 1);
            2'd2: layer_len_m1 = 7'(W_LEN2 - 1);
            2'd3: layer_len_m1 = 7'(W_LEN3 - 1);
            default: layer_len_m1 = 7'(W_LEN0 - 1);
        endcase
    end

    assign last_in_layer = (index == layer_len_m1);
    assign final_word    = last_in_layer && (layer == 2'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (xfer && (final_word || s_tlast)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            layer   <= 2'd0;
            index   <= 7'd0;
            err     <= 1'b0;
            w_tdata <= 32'h0;
        end else begin
            state   <= state_nxt;
            // Word is zero unless a fresh weight was accepted, so select bits never linger.
            w_tdata <= 32'h0;
            if (start_pass) begin
                layer <= 2'd0;
                index <= 7'd0;
                err   <= 1'b0;
            end
            if (xfer) begin
                w_tdata <= {4'b0000, 4'b0001 << layer, 1'b0, index, s_tdata};
                if (last_in_layer) begin
                    index <= 7'd0;
                    layer <= layer + 2'd1;
                end else begin
                    index <= index + 7'd1;
                end
                // tlast must coincide exactly with the final weight of the last layer.
                if (final_word != s_tlast) err <= 1'b1;
            end
        end
    end

`ifdef MLP_WLOAD_CHKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sum_q <= 16'h0;
        end else if (start_pass) begin
            sum_q <= 16'h0;
        end else if (xfer) begin
            sum_q <= sum_q + s_tdata;
        end
    end

    assign chksum = sum_q;
`else
    assign chksum = 16'h0;
`endif

endmodule
